// File: rtl/frame_pkg.sv
// frame_pkg: geometry and state encoding shared by the capture controller,
// the frame buffer and the LCD controller, so all of them agree on frame size
// and address width.
//   clog2()       : ceiling log2. Returns 0 for v <= 1.
//   frame_bytes() : IMG_W * IMG_H * BPP.
//   addr_bits()   : the byte address width inside one buffer (at least 1).
//   ST_*/state_t  : the capture FSM encoding, which is also shown on the LEDs.
package frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RECV   = 3'd1;
  localparam logic [2:0] ST_COMMIT = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DROP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RECV   = ST_RECV,
    S_COMMIT = ST_COMMIT,
    S_DRAIN  = ST_DRAIN,
    S_DROP   = ST_DROP
  } state_t;

  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int frame_bytes(input int w, input int h, input int bpp);
    return w * h * bpp;
  endfunction

  function automatic int addr_bits(input int w, input int h, input int bpp);
    int n;
    n = clog2(longint'(frame_bytes(w, h, bpp)));
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// frame_capture_ctrl_if: the byte stream coming from the SPI slave.
//   cs_n     : chip select, already synchronised to sys_clk. A low window frames one frame.
//   rx_data  : the received byte.
//   rx_valid : a one-cycle pulse for each byte.
//   rx_ready : the consumer accepts the byte. A byte transfers when rx_valid && rx_ready.
// master = the SPI byte source; slave = the capture controller.
interface frame_capture_ctrl_if;
  logic       cs_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output cs_n, output rx_data, output rx_valid, input rx_ready);
  modport slave  (input cs_n, input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/frame_buf_tracker.sv
// frame_buf_tracker: keeps track of which frame buffers are in use and the
// order in which they were published.
//   commit/commit_buf : a capture completed into commit_buf (push to the queue, mark busy).
//   ack               : the consumer releases the queue head. It is ignored when the queue is empty.
//   frame_valid       : the queue is not empty.
//   frame_buf         : the queue head.
//   free_any/free_idx : whether some buffer is free, and the lowest-index free buffer.
// A commit and an ack in the same cycle both take effect.
module frame_buf_tracker
  import frame_pkg::*;
#(
  parameter int NUM_BUFS = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic commit,
  input  logic commit_buf,
  input  logic ack,
  output logic frame_valid,
  output logic frame_buf,
  output logic free_any,
  output logic free_idx
);

  localparam int CNT_W = clog2(longint'(NUM_BUFS + 1));

  logic [NUM_BUFS-1:0] busy;
  // The publish queue. q[0] is the head. Each entry is one buffer-index bit.
  logic [NUM_BUFS-1:0] q, q_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                pop;

  assign pop = ack && (cnt != '0);

  // The pop shifts the queue first. The push then lands behind the entries that remain.
  // A push always has room, because the committed buffer was free and so it is not in the queue.
  always_comb begin
    q_n   = q;
    cnt_n = cnt;
    if (pop) begin
      for (int i = 0; i < NUM_BUFS - 1; i++) q_n[i] = q[i+1];
      q_n[NUM_BUFS-1] = 1'b0;
      cnt_n = cnt - CNT_W'(1);
    end
    if (commit) begin
      for (int i = 0; i < NUM_BUFS; i++)
        if (cnt_n == CNT_W'(i)) q_n[i] = commit_buf;
      cnt_n = cnt_n + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy <= '0;
      q    <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        if (pop && q[0] == 1'(i))         busy[i] <= 1'b0;
        if (commit && commit_buf == 1'(i)) busy[i] <= 1'b1;
      end
      q   <= q_n;
      cnt <= cnt_n;
    end
  end

  // Scan from the top down, so that the lowest free index is the last one written.
  always_comb begin
    free_any = 1'b0;
    free_idx = 1'b0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = 1'(i);
      end
    end
  end

  assign frame_valid = (cnt != '0);
  assign frame_buf   = (NUM_BUFS == 1) ? 1'b0 : q[0];

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: turns a byte stream framed by chip select into complete
// frames in one of NUM_BUFS frame buffers, and publishes each finished frame
// to a downstream consumer through frame_valid/frame_ack.
//   rx          : the byte stream (slave modport).
//   wr_*        : the frame buffer write port. It is registered, so it is valid the cycle after a byte is accepted.
//   frame_valid : a published frame is waiting in buffer frame_buf. frame_ack releases it.
//   frame_count : the number of published frames. It wraps at 2^16.
//   err_*       : one-cycle pulses for a short frame, an overlong frame, or a frame with no free buffer.
//   state_dbg   : the FSM state encoding.
module frame_capture_ctrl
  import frame_pkg::*;
#(
  parameter  int IMG_W       = 320,
  parameter  int IMG_H       = 240,
  parameter  int BPP         = 1,
  parameter  int NUM_BUFS    = 2,
  localparam int FRAME_BYTES = frame_bytes(IMG_W, IMG_H, BPP),
  localparam int ADDR_W      = addr_bits(IMG_W, IMG_H, BPP)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  frame_capture_ctrl_if.slave  rx,
  output logic                 wr_en,
  output logic                 wr_buf,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [7:0]           wr_data,
  output logic                 frame_valid,
  output logic                 frame_buf,
  input  logic                 frame_ack,
  output logic [15:0]          frame_count,
  output logic                 err_short,
  output logic                 err_overrun,
  output logic                 err_drop,
  output logic [2:0]           state_dbg
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic              cap_buf;
  logic              ovr_seen;
  logic              rx_ready_q;
  logic              fire, last, commit;
  logic              wr_c, short_c, ovr_c, drop_c;
  logic              free_any, free_idx;

  assign fire   = rx.rx_valid && rx_ready_q;
  assign last   = (addr == ADDR_W'(FRAME_BYTES - 1));
  assign commit = (state == S_COMMIT);

  always_comb begin
    state_n = state;
    wr_c    = 1'b0;
    short_c = 1'b0;
    ovr_c   = 1'b0;
    drop_c  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx.cs_n) begin
          state_n = free_any ? S_RECV : S_DROP;
          drop_c  = !free_any;
        end
      end
      S_RECV: begin
        wr_c = fire;
        // If the final byte and the rise of chip select land in the same cycle, the frame still completes.
        if (fire && last) state_n = S_COMMIT;
        else if (rx.cs_n) begin
          state_n = S_IDLE;
          short_c = 1'b1;
        end
      end
      S_COMMIT: state_n = rx.cs_n ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        ovr_c = fire && !ovr_seen;
        if (rx.cs_n) state_n = S_IDLE;
      end
      S_DROP:  if (rx.cs_n) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      cap_buf     <= 1'b0;
      ovr_seen    <= 1'b0;
      rx_ready_q  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_count <= '0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
      err_drop    <= 1'b0;
    end else begin
      state       <= state_n;
      // Registered from the next state, so that rx_ready follows the current state and still resets low.
      rx_ready_q  <= (state_n != S_COMMIT);
      wr_en       <= wr_c;
      err_short   <= short_c;
      err_overrun <= ovr_c;
      err_drop    <= drop_c;
      if (wr_c) begin
        wr_addr <= addr;
        wr_data <= rx.rx_data;
      end
      if (state == S_IDLE && state_n == S_RECV) begin
        addr    <= '0;
        cap_buf <= free_idx;
      end else if (wr_c && !last) begin
        addr <= addr + ADDR_W'(1);
      end
      if (commit)     ovr_seen <= 1'b0;
      else if (ovr_c) ovr_seen <= 1'b1;
      if (commit) frame_count <= frame_count + 16'd1;
    end
  end

  assign rx.rx_ready = rx_ready_q;
  assign wr_buf      = (NUM_BUFS == 1) ? 1'b0 : cap_buf;
  assign state_dbg   = state;

  frame_buf_tracker #(.NUM_BUFS(NUM_BUFS)) u_tracker (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .commit      (commit),
    .commit_buf  (cap_buf),
    .ack         (frame_ack),
    .frame_valid (frame_valid),
    .frame_buf   (frame_buf),
    .free_any    (free_any),
    .free_idx    (free_idx)
  );

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Parametrised frame capture controller between the SPI byte-stream slave and the on-chip image frame buffer. It turns a chip-select-framed byte stream into complete frames written to one of one or two frame buffers, and hands each finished frame to a downstream consumer (LCD controller, processing) through a valid/ack handshake. Short, overlong and unbufferable frames are detected and reported, never published.

## Interface
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- BPP, 1, bytes per pixel (1 or 2)
- NUM_BUFS, 2, frame buffers (1 or 2)
- FRAME_BYTES, IMG_W*IMG_H*BPP, derived; not overridable
- ADDR_W, clog2(FRAME_BYTES), derived
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- cs_n  in  1  chip select, already synchronised to sys_clk
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid, single-cycle pulse per byte
- rx_ready  out  1  byte accept; reset 0
- wr_en  out  1  buffer write strobe; reset 0
- wr_buf  out  1  target buffer index; reset 0
- wr_addr  out  ADDR_W  byte address within buffer; reset 0
- wr_data  out  8  byte to write; reset 0
- frame_valid  out  1  a published frame is waiting; reset 0
- frame_buf  out  1  buffer index of the oldest published frame; reset 0
- frame_ack  in  1  consumer releases frame_buf, single-cycle
- frame_count  out  16  published frames, wraps at 2^16; reset 0
- err_short  out  1  pulse: cs_n rose before FRAME_BYTES bytes; reset 0
- err_overrun  out  1  pulse: byte received after frame full; reset 0
- err_drop  out  1  pulse: frame started with no free buffer; reset 0
- state_dbg  out  3  current state encoding, for LEDs; reset IDLE

## Operation
- States: IDLE, RECV, COMMIT, DRAIN, DROP.
- IDLE: rx_ready=1, bytes discarded. On cs_n=0 with a free buffer: select it, clear the address counter, go to RECV. On cs_n=0 with no free buffer: pulse err_drop, go to DROP.
- RECV: each accepted byte (rx_valid && rx_ready) is written at wr_addr, then the address increments. When byte FRAME_BYTES-1 is accepted, go to COMMIT. If cs_n=1 first: pulse err_short, leave the buffer free, go to IDLE.
- COMMIT, one cycle: rx_ready=0. Mark the buffer busy and append it to the publish queue. Increment frame_count. If cs_n=0, go to DRAIN, else to IDLE.
- DRAIN: rx_ready=1. The first byte accepted pulses err_overrun once per frame; all bytes are discarded. On cs_n=1, go to IDLE.
- DROP: rx_ready=1, bytes discarded. On cs_n=1, go to IDLE.
- Buffer tracking: each buffer has a busy flag, and there is an in-order queue of depth NUM_BUFS.
  - frame_valid = queue not empty; frame_buf = queue head.
  - frame_ack with frame_valid=1 pops the head and clears its busy flag. frame_ack with frame_valid=0 is ignored.
  - Capture picks the lowest-index free buffer.
  - When NUM_BUFS=1, wr_buf and frame_buf are tied to 0.
- A commit and an ack in the same cycle both take effect; the queue count is unchanged if the queue was non-empty.
- Address counter width is ADDR_W. The counter never exceeds FRAME_BYTES-1; it is cleared on entry to RECV.

## Timing
- Byte accepted in cycle N → wr_en/wr_addr/wr_data registered and valid in cycle N+1, held for one cycle.
- Last byte accepted in cycle N → state COMMIT in N+1 (final wr_en also in N+1) → frame_valid and frame_count update in N+2.
- The ack in cycle M frees the buffer from cycle M+1. A capture starting in M+1 may use it.
- Error pulses are exactly one cycle wide, asserted the cycle after the triggering condition.
- cs_n low to RECV entry: 1 cycle. A byte arriving in the same cycle as the transition is discarded.
- sys_rst_n asserted at any time: all outputs go to their reset values, all buffers are freed, the queue is emptied, and any partial frame is lost.

## Structure
- Shared package frame_pkg holds:
  - the state encoding localparams;
  - the clog2 function;
  - the FRAME_BYTES/ADDR_W derivation, so the frame buffer and LCD controller use identical geometry.
- One sub-module, frame_buf_tracker: busy flags, publish queue, frame_valid/frame_buf, commit/ack arbitration.
- The FSM and address counter stay in frame_capture_ctrl.

## Test plan
Use IMG_W=4, IMG_H=2, BPP=1 (FRAME_BYTES=8) unless stated.
- Normal frame: cs_n low, 8 bytes 0x10..0x17, cs_n high → 8 wr_en on buf 0, addr 0..7; frame_valid=1, frame_buf=0, frame_count=1.
- Short frame: cs_n low, 5 bytes, cs_n high → err_short one pulse; frame_valid stays 0; the next full frame also lands in buf 0.
- Overrun: 10 bytes in one cs_n window → 8 writes; err_overrun exactly one pulse; bytes 9–10 not written.
- Ping-pong (NUM_BUFS=2): two frames, no ack → frame_buf=0; ack → frame_buf=1, frame_valid stays 1; second ack → frame_valid=0.
- No free buffer: two unacked frames, then a third → err_drop pulse, no wr_en, frame_count=2. Ack and commit driven in the same cycle → queue count held.
- Reset mid-frame: sys_rst_n low after 3 bytes → all outputs at reset values immediately; a subsequent full frame publishes to buf 0 with frame_count=1.
